// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one word-addressed backing store between the I-cache refill path and
// the D-cache refill/write-back path. Each granted line transaction takes a
// fixed LATENCY cycles from grant to a one-cycle done pulse on the owning port.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset (aborts any in-flight transaction)
//   iLoad       I refill request, held until iDone
//   iLineAddr   I line address
//   iDataOut    last I refill line {mem[2a+1], mem[2a]}
//   iDone       one-cycle I completion pulse
//   dLoad       D refill request, held until dDone
//   dWrite      D write-back request, held until dDone (served before dLoad)
//   dLineAddr   D line address (shared by dLoad and dWrite)
//   dWriteData  write-back line, [31:0] -> mem[2a], [63:32] -> mem[2a+1]
//   dDataOut    last D refill line
//   dDone       one-cycle D completion pulse
//   busy        high while a transaction is in BUSY or DONE
//   grantD      owner of the current/last transaction (1 = D, 0 = I)
module mem_arbiter #(
  parameter int LINE_ADDR_W = 2,
  parameter int LATENCY     = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iLoad,
  input  logic [LINE_ADDR_W-1:0] iLineAddr,
  output logic [63:0]            iDataOut,
  output logic                   iDone,
  input  logic                   dLoad,
  input  logic                   dWrite,
  input  logic [LINE_ADDR_W-1:0] dLineAddr,
  input  logic [63:0]            dWriteData,
  output logic [63:0]            dDataOut,
  output logic                   dDone,
  output logic                   busy,
  output logic                   grantD
);

  localparam int          WORDS    = 2 ** (LINE_ADDR_W + 1);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_cnt;
  logic                   r_port_d;
  logic                   r_write;
  logic [LINE_ADDR_W-1:0] r_addr;
  logic [63:0]            r_wdata;
  logic                   r_last_d;
  logic [31:0]            r_mem [0:WORDS-1];

  logic                   w_grant;
  logic                   w_grant_d;
  logic                   w_commit;
  logic [LINE_ADDR_W:0]   w_lo_idx;
  logic [LINE_ADDR_W:0]   w_hi_idx;
  logic [63:0]            w_rd_line;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    if (iLoad && (dLoad || dWrite)) begin
      w_grant   = 1'b1;
      w_grant_d = ~r_last_d;
    end else if (iLoad) begin
      w_grant   = 1'b1;
      w_grant_d = 1'b0;
    end else if (dLoad || dWrite) begin
      w_grant   = 1'b1;
      w_grant_d = 1'b1;
    end else begin
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  // Next-state logic and the commit strobe at the BUSY->DONE boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_DONE;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word indices of the latched line and the line as currently stored.
  always_comb begin
    w_lo_idx  = {r_addr, 1'b0};
    w_hi_idx  = {r_addr, 1'b1};
    w_rd_line = {r_mem[w_hi_idx], r_mem[w_lo_idx]};
  end

  // Control state, transaction latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_port_d <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 64'd0;
      r_last_d <= 1'b1;
      grantD   <= 1'b0;
      busy     <= 1'b0;
      iDone    <= 1'b0;
      dDone    <= 1'b0;
      iDataOut <= 64'd0;
      dDataOut <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      iDone   <= w_commit & ~r_port_d;
      dDone   <= w_commit & r_port_d;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            // Write-back takes precedence over refill on the D port.
            r_port_d <= w_grant_d;
            r_write  <= w_grant_d & dWrite;
            r_addr   <= w_grant_d ? dLineAddr : iLineAddr;
            r_wdata  <= dWriteData;
            r_cnt    <= CNT_LOAD;
            r_last_d <= w_grant_d;
            grantD   <= w_grant_d;
          end
        end
        S_BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
          if (w_commit && !r_write) begin
            if (r_port_d) begin
              dDataOut <= w_rd_line;
            end else begin
              iDataOut <= w_rd_line;
            end
          end
        end
        S_DONE: begin
          r_cnt <= 8'd0;
        end
        default: begin
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Backing store: cleared on reset, written as a line pair on write commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WORDS; k++) begin
        r_mem[k] <= 32'd0;
      end
    end else begin
      if (w_commit && r_write) begin
        r_mem[w_lo_idx] <= r_wdata[31:0];
        r_mem[w_hi_idx] <= r_wdata[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iLoad = 1'b0;
  logic [1:0]  iLineAddr = 2'd0;
  logic [63:0] iDataOut;
  logic        iDone;
  logic        dLoad = 1'b0;
  logic        dWrite = 1'b0;
  logic [1:0]  dLineAddr = 2'd0;
  logic [63:0] dWriteData = 64'd0;
  logic [63:0] dDataOut;
  logic        dDone;
  logic        busy;
  logic        grantD;

  mem_arbiter #(.LINE_ADDR_W(2), .LATENCY(20)) dut (
    .clk(clk), .reset(reset),
    .iLoad(iLoad), .iLineAddr(iLineAddr), .iDataOut(iDataOut), .iDone(iDone),
    .dLoad(dLoad), .dWrite(dWrite), .dLineAddr(dLineAddr),
    .dWriteData(dWriteData), .dDataOut(dDataOut), .dDone(dDone),
    .busy(busy), .grantD(grantD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    bit          chk;
    int          done_cyc;
    bit          gd;
  } exp_t;

  exp_t qi[$];
  exp_t qd[$];

  localparam logic [63:0] D_A = 64'hFFFFAAAA_AAAAFFFF;
  localparam logic [63:0] D_B = 64'hAAAFFFAF_FFFAAAFA;
  localparam logic [63:0] D_C = 64'h01234567_89ABCDEF;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit port_d, input logic [63:0] data, input bit chk,
                          input int done_cyc);
    exp_t e;
    e.data = data; e.chk = chk; e.done_cyc = done_cyc; e.gd = port_d;
    if (port_d) qd.push_back(e);
    else        qi.push_back(e);
  endtask

  task automatic pop_cmp(input bit port_d);
    exp_t e;
    if ((port_d ? qd.size() : qi.size()) == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_done: port_d=%0d got done expected none (cycle %0d)", port_d, cyc);
    end else begin
      e = port_d ? qd.pop_front() : qi.pop_front();
      check64(port_d ? "d_done_cycle" : "i_done_cycle", 64'(cyc), 64'(e.done_cyc));
      check64(port_d ? "d_grantD" : "i_grantD", {63'd0, grantD}, {63'd0, e.gd});
      if (e.chk) check64(port_d ? "dDataOut" : "iDataOut", port_d ? dDataOut : iDataOut, e.data);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (iDone || dDone) begin
        check64("done_exclusive", {63'd0, iDone & dDone}, 64'd0);
        check64("busy_in_done", {63'd0, busy}, 64'd1);
      end
      if (iDone) pop_cmp(1'b0);
      if (dDone) pop_cmp(1'b1);
    end
  end

  task automatic wait_done(input bit port_d);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #2;
      if (port_d ? dDone : iDone) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: port_d=%0d got no done expected done within 200 cycles", port_d);
    end
  endtask

  task automatic i_txn(input logic [1:0] a);
    iLineAddr = a;
    iLoad = 1'b1;
    wait_done(1'b0);
    iLoad = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic d_txn(input bit wr, input bit ld, input logic [1:0] a, input logic [63:0] data);
    dLineAddr = a;
    dWriteData = data;
    dWrite = wr;
    dLoad = ld;
    if (wr) begin
      wait_done(1'b1);
      dWrite = 1'b0;
    end
    if (ld) begin
      wait_done(1'b1);
      dLoad = 1'b0;
    end
    @(posedge clk); #2;
  endtask

  task automatic check_outputs_zero(input string tag);
    check64({tag, "_iDataOut"}, iDataOut, 64'd0);
    check64({tag, "_dDataOut"}, dDataOut, 64'd0);
    check64({tag, "_iDone"}, {63'd0, iDone}, 64'd0);
    check64({tag, "_dDone"}, {63'd0, dDone}, 64'd0);
    check64({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check64({tag, "_grantD"}, {63'd0, grantD}, 64'd0);
  endtask

  initial begin
    int k;
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Tie after reset: I first, D one transaction (22 cycles) later.
    k = cyc;
    push_exp(1'b0, 64'd0, 1'b1, k + 21);
    push_exp(1'b1, 64'd0, 1'b1, k + 43);
    fork
      i_txn(2'd1);
      d_txn(1'b0, 1'b1, 2'd0, 64'd0);
    join

    // Write-back then refill of the same line through the other port.
    k = cyc;
    push_exp(1'b1, 64'd0, 1'b0, k + 21);
    d_txn(1'b1, 1'b0, 2'd1, D_A);
    @(posedge clk); #2;
    check64("busy_idle", {63'd0, busy}, 64'd0);
    k = cyc;
    push_exp(1'b0, D_A, 1'b1, k + 21);
    i_txn(2'd1);

    // dWrite and dLoad together: write first, then the refill sees it.
    k = cyc;
    push_exp(1'b1, 64'd0, 1'b0, k + 21);
    push_exp(1'b1, D_B, 1'b1, k + 43);
    d_txn(1'b1, 1'b1, 2'd3, D_B);

    // Persistent contention: I, D, I, D, 22 cycles apart.
    k = cyc;
    push_exp(1'b0, D_B, 1'b1, k + 21);
    push_exp(1'b1, D_A, 1'b1, k + 43);
    push_exp(1'b0, D_B, 1'b1, k + 65);
    push_exp(1'b1, D_A, 1'b1, k + 87);
    fork
      begin i_txn(2'd3); i_txn(2'd3); end
      begin d_txn(1'b0, 1'b1, 2'd1, 64'd0); d_txn(1'b0, 1'b1, 2'd1, 64'd0); end
    join

    // Reset 10 cycles into a write-back: aborted, everything cleared.
    dLineAddr = 2'd2;
    dWriteData = 64'h12345678_9ABCDEF0;
    dWrite = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    dWrite = 1'b0;
    #1 check_outputs_zero("abort");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    k = cyc;
    push_exp(1'b0, 64'd0, 1'b1, k + 21);
    i_txn(2'd2);
    k = cyc;
    push_exp(1'b1, 64'd0, 1'b1, k + 21);
    d_txn(1'b0, 1'b1, 2'd1, 64'd0);

    // Address and data changed during BUSY must not affect the transaction.
    k = cyc;
    push_exp(1'b1, 64'd0, 1'b0, k + 21);
    fork
      d_txn(1'b1, 1'b0, 2'd0, D_C);
      begin
        repeat (5) @(posedge clk);
        #3 dLineAddr = 2'd3;
        dWriteData = 64'hFFFFFFFF_FFFFFFFF;
      end
    join
    k = cyc;
    push_exp(1'b0, D_C, 1'b1, k + 21);
    i_txn(2'd0);
    k = cyc;
    push_exp(1'b0, 64'd0, 1'b1, k + 21);
    i_txn(2'd3);

    repeat (3) @(posedge clk);
    check64("queues_drained", 64'(qi.size() + qd.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Main-memory arbiter and sequencer that shares one backing store of 32-bit words between the instruction-cache and data-cache miss/write-back paths. Requests are level-held line transactions: 64-bit refills and 64-bit write-backs. Each granted transaction runs for a fixed access latency and completes with a one-cycle done pulse to the owning cache controller. The block sits between the two cache controllers and main memory and replaces per-cache direct memory access.

## Interface
- LINE_ADDR_W, 2, line-address width; memory holds 2^(LINE_ADDR_W+1) words (default 8).
- LATENCY, 20, cycles from grant to done; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iLoad  in  1  I-cache refill request, level-held until iDone.
- iLineAddr  in  LINE_ADDR_W  I-cache line address.
- iDataOut  out  64  refill line {mem[2a+1], mem[2a]}; held until next I read completes.
- iDone  out  1  one-cycle completion pulse, I port.
- dLoad  in  1  D-cache refill request, level-held until dDone.
- dWrite  in  1  D-cache write-back request, level-held until dDone.
- dLineAddr  in  LINE_ADDR_W  D-cache line address; shared by dLoad and dWrite.
- dWriteData  in  64  write-back line; [31:0] goes to mem[2a], [63:32] to mem[2a+1].
- dDataOut  out  64  refill line for D; held until next D read completes.
- dDone  out  1  one-cycle completion pulse, D port.
- busy  out  1  high in BUSY and DONE.
- grantD  out  1  owner of current or last transaction: 1 = D, 0 = I.

## Operation
- States:
  - IDLE: evaluate requests. If any are pending, latch port, op, address and write data; load counter with LATENCY-1; go to BUSY.
  - BUSY: decrement the counter. At zero, commit the operation and go to DONE.
  - DONE: assert the owning port's done for exactly one cycle, then return to IDLE.
- Arbitration in IDLE:
  - Only one port pending: grant it.
  - Both pending: round-robin. Grant the port not granted last; lastGrant resets to D, so I wins the first tie.
- D-port ordering: if dWrite and dLoad are both high, the write-back is serviced first, as its own transaction with its own dDone. dLoad is then serviced as a later, separately arbitrated transaction.
- Address and write data are captured at grant. Input changes during BUSY are ignored.
- Commit happens at the BUSY→DONE edge:
  - Write: two memory words written.
  - Read: the owning port's data register is loaded.
  - The other port's data register is unchanged.
- Requester rule: the requester deasserts the completed request during the DONE cycle, so it is low in the following IDLE cycle. A request still high in IDLE is treated as a new transaction.
- Reset (asynchronous, any state):
  - State → IDLE; counter cleared.
  - All outputs → 0 (iDataOut, dDataOut, iDone, dDone, busy, grantD); lastGrant → D.
  - All memory words cleared to 0.
  - An in-flight transaction is aborted with no memory write and no done pulse.

## Timing
- Request high in IDLE at edge t0: granted at t0. done is high for the single cycle t0+LATENCY → t0+LATENCY+1. The next grant is no earlier than edge t0+LATENCY+2.
- Back-to-back contention: each transaction occupies LATENCY+2 cycles, counted from first IDLE sample to the next IDLE.
- busy rises at the grant edge and falls at the DONE→IDLE edge.
- iDone and dDone are never high together. done is never asserted for a port that has no granted transaction.
- Read data is valid on the same edge the done pulse rises.
- Read-after-write to the same line returns the written data, because the write commits before any later grant.

## Test plan
- Reset, then dWrite line 1 with 64'hFFFFAAAA_AAAAFFFF, then iLoad line 1. Required: dDone at t0+20; iDataOut = 64'hFFFFAAAA_AAAAFFFF; mem[2] = 32'hAAAAFFFF.
- iLoad and dLoad asserted in the same IDLE cycle after reset. Required: I granted first (grantD = 0), iDone at t0+20; D granted at t0+22, dDone at t0+42.
- dWrite and dLoad both high on line 3 with data 64'hAAAFFFAF_FFFAAAFA. Required: write completes first; the following dLoad returns the same value on dDataOut.
- Persistent contention over 4 transactions. Required: grants alternate I, D, I, D; each transaction spans 22 cycles.
- Reset asserted 10 cycles into a write-back. Required: outputs immediately 0; no dDone; subsequent read of that line returns 0.
- dLineAddr toggled during BUSY. Required: the latched address is used, and the data reflects the line granted.
